// File: rtl/uart_tx_framer_pkg.sv
// uart_tx_framer_pkg: shared widths, frame markers and frame state encoding
package uart_tx_framer_pkg;
  localparam int NB_DATA = 8;
  localparam int NB_STATE = 3;
  localparam int FRAME_LEN = 5;
  localparam logic [NB_DATA-1:0] SOF_BYTE = 8'hA5;
  localparam logic [NB_DATA-1:0] EOF_BYTE = 8'h5A;
  typedef enum logic [NB_STATE-1:0] {
    IDLE = 3'd0,
    SOF  = 3'd1,
    SEQ  = 3'd2,
    PAY  = 3'd3,
    CHK  = 3'd4,
    EOF  = 3'd5
  } state_e;
  function automatic state_e next_state(input state_e s);
    return s == SOF ? SEQ : s == SEQ ? PAY : s == PAY ? CHK : s == CHK ? EOF : IDLE;
  endfunction
endpackage

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: result strobe in, TX FIFO write port and drop status out
interface uart_tx_framer_if;
  import uart_tx_framer_pkg::*;
  logic               i_data_valid;
  logic [NB_DATA-1:0] i_data;
  logic               i_tx_full;
  logic               o_wr;
  logic [NB_DATA-1:0] o_data;
  logic               o_busy;
  logic               o_drop;
  logic [NB_DATA-1:0] o_drop_cnt;
  modport master(output i_data_valid, i_data, i_tx_full, input o_wr, o_data, o_busy, o_drop, o_drop_cnt);
  modport slave(input i_data_valid, i_data, i_tx_full, output o_wr, o_data, o_busy, o_drop, o_drop_cnt);
endinterface

// File: rtl/tx_frame_hold.sv
// tx_frame_hold: single-entry result buffer; a load on a take cycle keeps the new byte
module tx_frame_hold
  import uart_tx_framer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [NB_DATA-1:0] data,
  input  logic               take,
  output logic               valid,
  output logic [NB_DATA-1:0] q
);
  logic               valid_d, valid_q;
  logic [NB_DATA-1:0] q_d, q_q;
  always_comb begin
    valid_d = load | (valid_q & ~take);
    q_d = load ? data : q_q;
  end
  always_ff @(posedge clk) begin
    valid_q <= reset & valid_d;
    q_q <= reset ? q_d : '0;
  end
  assign valid = valid_q;
  assign q = q_q;
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: wraps each result byte in SOF/SEQ/PAY/CHK/EOF and writes it to the TX FIFO
module uart_tx_framer
  import uart_tx_framer_pkg::*;
(
  input logic             clk,
  input logic             reset,
  uart_tx_framer_if.slave bus
);
  state_e             state_q, state_d;
  logic [NB_DATA-1:0] cur_q, cur_d, seq_q, seq_d, cnt_q, cnt_d, hold_q;
  logic               busy, wr, last, hold_valid, hold_load, drop;
  always_comb begin
    busy = state_q != IDLE;
    wr = busy & ~bus.i_tx_full;
    last = wr & (state_q == EOF);
    hold_load = bus.i_data_valid & busy & (last ? hold_valid : ~hold_valid);
    drop = bus.i_data_valid & busy & ~last & hold_valid;
    state_d = !busy ? (bus.i_data_valid ? SOF : IDLE)
            : !wr ? state_q
            : !last ? next_state(state_q)
            : (hold_valid | bus.i_data_valid) ? SOF : IDLE;
    cur_d = (!busy && bus.i_data_valid) ? bus.i_data
          : !last ? cur_q
          : hold_valid ? hold_q
          : bus.i_data_valid ? bus.i_data : cur_q;
    seq_d = seq_q + {{(NB_DATA-1){1'b0}}, last};
    cnt_d = cnt_q + {{(NB_DATA-1){1'b0}}, drop & (cnt_q != '1)};
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? state_d : IDLE;
    cur_q <= reset ? cur_d : '0;
    seq_q <= reset ? seq_d : '0;
    cnt_q <= reset ? cnt_d : '0;
  end
  tx_frame_hold u_hold (
    .clk  (clk),
    .reset(reset),
    .load (hold_load),
    .data (bus.i_data),
    .take (last & hold_valid),
    .valid(hold_valid),
    .q    (hold_q)
  );
  assign bus.o_wr = wr;
  assign bus.o_busy = busy;
  assign bus.o_drop = drop;
  assign bus.o_drop_cnt = cnt_q;
  assign bus.o_data = state_q == SOF ? SOF_BYTE
                    : state_q == SEQ ? seq_q
                    : state_q == PAY ? cur_q
                    : state_q == CHK ? SOF_BYTE ^ seq_q ^ cur_q
                    : state_q == EOF ? EOF_BYTE : '0;
endmodule
